// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared encodings for the MEM stage: funct3 access size codes
//               and the load/store FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    // Load/store size and sign codes carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM stage controller states
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane steering. Builds store byte enables and
//               replicated write data, extracts and extends load data, and
//               flags misaligned half/word accesses. Unknown funct3 codes
//               behave as a word access.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = load_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    // Decode access size into lanes, extension and alignment check
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data;
        load_data   = load_word;
        misalign    = |addr_lo;
        case (funct3)
            F3_LB, F3_LBU: begin
                store_be    = 4'b0001 << addr_lo;
                store_wdata = {4{store_data[7:0]}};
                load_data   = (funct3 == F3_LB) ? {{24{ld_byte[7]}}, ld_byte}
                                                : {24'h0, ld_byte};
                misalign    = 1'b0;
            end
            F3_LH, F3_LHU: begin
                store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{store_data[15:0]}};
                load_data   = (funct3 == F3_LH) ? {{16{ld_half[15]}}, ld_half}
                                                : {16'h0, ld_half};
                misalign    = addr_lo[0];
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_data;
                load_data   = load_word;
                misalign    = |addr_lo;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_lsu_stage
// Description : MEM stage with MEM/WB pipeline register. Issues loads/stores
//               on a req/ready data port with a timeout abort, stalls the
//               upstream pipe while an access is outstanding and registers
//               the result for write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_lsu_stage
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic        MemWrite_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    input  logic [4:0]  rdAddr_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        RegWrite_wb,
    output logic        MemtoReg_wb,
    output logic [4:0]  rdAddr_wb,
    output logic [31:0] ALUResult_wb,
    output logic [31:0] MemReadData_wb
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;

    logic        mem_op;
    logic        misalign;
    logic        timeout;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_ext;

    assign mem_op  = MemtoReg_mem | MemWrite_mem;
    assign timeout = (count == CNT_LAST);

    load_store_align u_align (
        .funct3      (funct3_mem),
        .addr_lo     (ALUResult_mem[1:0]),
        .store_data  (MemWriteData_mem),
        .load_word   (dmem_rdata),
        .store_be    (store_be),
        .store_wdata (store_wdata),
        .load_data   (load_ext),
        .misalign    (misalign)
    );

    // Request is a pure state decode so reset drops it on the very next cycle
    assign dmem_req   = (state == S_ACCESS);
    assign dmem_we    = MemWrite_mem;
    assign dmem_addr  = {ALUResult_mem[31:2], 2'b00};
    assign dmem_be    = MemWrite_mem ? store_be : 4'b0000;
    assign dmem_wdata = store_wdata;

    // Per-cycle hazard and exception indications
    always_comb begin
        stall_mem    = 1'b0;
        misalign_exc = 1'b0;
        bus_err      = 1'b0;
        case (state)
            S_IDLE: begin
                misalign_exc = mem_op & misalign;
                stall_mem    = mem_op & ~misalign;
            end
            S_ACCESS: begin
                if (!dmem_ready) begin
                    if (timeout) bus_err   = 1'b1;
                    else         stall_mem = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Access FSM, timeout counter and MEM/WB register; WB sees a bubble
    // (no write, no load) on every edge that does not retire an instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            count          <= '0;
            RegWrite_wb    <= 1'b0;
            MemtoReg_wb    <= 1'b0;
            rdAddr_wb      <= 5'd0;
            ALUResult_wb   <= 32'd0;
            MemReadData_wb <= 32'd0;
        end else begin
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!mem_op) begin
                        RegWrite_wb  <= RegWrite_mem;
                        rdAddr_wb    <= rdAddr_mem;
                        ALUResult_wb <= ALUResult_mem;
                    end else if (!misalign) begin
                        state <= S_ACCESS;
                        count <= '0;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        RegWrite_wb    <= RegWrite_mem & MemtoReg_mem;
                        MemtoReg_wb    <= MemtoReg_mem;
                        rdAddr_wb      <= rdAddr_mem;
                        ALUResult_wb   <= ALUResult_mem;
                        MemReadData_wb <= load_ext;
                        state          <= S_IDLE;
                    end else if (timeout) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_lsu_stage
// Description : Scoreboard bench for mem_wb_lsu_stage. The driver issues
//               directed operations and queues expected results; a monitor
//               collects per-instruction activity and checks each retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_lsu_stage;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] ALUResult_mem, MemWriteData_mem;
    logic [4:0]  rdAddr_mem;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_mem, misalign_exc, bus_err;
    logic        RegWrite_wb, MemtoReg_wb;
    logic [4:0]  rdAddr_wb;
    logic [31:0] ALUResult_wb, MemReadData_wb;

    always #5 clk = ~clk;

    mem_wb_lsu_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem), .MemWrite_mem(MemWrite_mem),
        .funct3_mem(funct3_mem), .ALUResult_mem(ALUResult_mem),
        .MemWriteData_mem(MemWriteData_mem), .rdAddr_mem(rdAddr_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .misalign_exc(misalign_exc), .bus_err(bus_err),
        .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb), .rdAddr_wb(rdAddr_wb),
        .ALUResult_wb(ALUResult_wb), .MemReadData_wb(MemReadData_wb)
    );

    typedef struct {
        logic        bubble;
        logic        rw, mtr;
        logic [4:0]  rd;
        logic [31:0] alu, mrd;
        logic        chk_mrd;
        int          req_cyc, stall_cyc;
        int          mis, berr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    logic vld    = 1'b0;
    logic mon_en = 1'b0;

    function automatic exp_t mk(logic bub, logic rw, logic mtr, logic [4:0] rd,
                                logic [31:0] alu, logic chk, logic [31:0] mrd,
                                int rq, int st, int mis, int berr);
        exp_t e;
        e.bubble = bub; e.rw = rw; e.mtr = mtr; e.rd = rd; e.alu = alu;
        e.chk_mrd = chk; e.mrd = mrd; e.req_cyc = rq; e.stall_cyc = st;
        e.mis = mis; e.berr = berr;
        return e;
    endfunction

    function automatic req_t mkr(logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = a; r.be = be; r.wdata = wd;
        return r;
    endfunction

    // Monitor: accumulates activity per instruction, checks on retirement
    initial begin : monitor
        logic retire_prev, req_prev, ok;
        int   s_req, s_stall, s_mis, s_berr;
        exp_t e;
        req_t r;
        retire_prev = 1'b0; req_prev = 1'b0;
        s_req = 0; s_stall = 0; s_mis = 0; s_berr = 0;
        forever begin
            @(negedge clk); #2;
            if (!mon_en) begin
                retire_prev = 1'b0; req_prev = 1'b0;
                s_req = 0; s_stall = 0; s_mis = 0; s_berr = 0;
                continue;
            end
            if (retire_prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: retirement with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if (e.bubble)
                        ok = (RegWrite_wb == 1'b0) && (MemtoReg_wb == 1'b0);
                    else
                        ok = (RegWrite_wb == e.rw) && (MemtoReg_wb == e.mtr) &&
                             (rdAddr_wb == e.rd) && (ALUResult_wb == e.alu) &&
                             (!e.chk_mrd || (MemReadData_wb == e.mrd));
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL wb_regs: got rw=%0b mtr=%0b rd=%0d alu=%h mrd=%h, want bubble=%0b rw=%0b mtr=%0b rd=%0d alu=%h mrd=%h",
                                 RegWrite_wb, MemtoReg_wb, rdAddr_wb, ALUResult_wb, MemReadData_wb,
                                 e.bubble, e.rw, e.mtr, e.rd, e.alu, e.mrd);
                    end
                    checks++;
                    if (s_req != e.req_cyc) begin
                        errors++;
                        $display("FAIL req_cycles: got %0d want %0d", s_req, e.req_cyc);
                    end
                    checks++;
                    if (s_stall != e.stall_cyc) begin
                        errors++;
                        $display("FAIL stall_cycles: got %0d want %0d", s_stall, e.stall_cyc);
                    end
                    checks++;
                    if (s_mis != e.mis || s_berr != e.berr) begin
                        errors++;
                        $display("FAIL exc_pulses: got misalign=%0d bus_err=%0d want misalign=%0d bus_err=%0d",
                                 s_mis, s_berr, e.mis, e.berr);
                    end
                end
                s_req = 0; s_stall = 0; s_mis = 0; s_berr = 0;
            end
            if (vld) begin
                if (dmem_req && !req_prev) begin
                    checks++;
                    if (req_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: addr=%h", dmem_addr);
                    end else begin
                        r = req_q.pop_front();
                        if (dmem_we != r.we || dmem_addr != r.addr || dmem_be != r.be ||
                            (r.we && dmem_wdata != r.wdata)) begin
                            errors++;
                            $display("FAIL req_fields: got we=%0b addr=%h be=%b wdata=%h want we=%0b addr=%h be=%b wdata=%h",
                                     dmem_we, dmem_addr, dmem_be, dmem_wdata, r.we, r.addr, r.be, r.wdata);
                        end
                    end
                end
                if (dmem_req)     s_req++;
                if (stall_mem)    s_stall++;
                if (misalign_exc) s_mis++;
                if (bus_err)      s_berr++;
            end
            req_prev    = dmem_req;
            retire_prev = vld && !stall_mem;
        end
    end

    task automatic clear_inputs();
        MemtoReg_mem = 1'b0; RegWrite_mem = 1'b0; MemWrite_mem = 1'b0;
        funct3_mem = 3'b000; ALUResult_mem = 32'h0; MemWriteData_mem = 32'h0;
        rdAddr_mem = 5'd0;
    endtask

    // Driver: presents one instruction and plays the memory side; rdy_after<0 = never ready
    task automatic run_op(input logic mtr, input logic rw, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int rdy_after, input logic [31:0] rdata,
                          input exp_t e, input logic has_req, input req_t r);
        int   nreq, cyc;
        logic done;
        exp_q.push_back(e);
        if (has_req) req_q.push_back(r);
        MemtoReg_mem = mtr; RegWrite_mem = rw; MemWrite_mem = mw; funct3_mem = f3;
        ALUResult_mem = addr; MemWriteData_mem = wd; rdAddr_mem = rd;
        vld = 1'b1; nreq = 0; cyc = 0;
        forever begin
            @(negedge clk); #1;
            dmem_ready = dmem_req && (rdy_after >= 0) && (nreq == rdy_after);
            dmem_rdata = dmem_ready ? rdata : 32'h0;
            if (dmem_req) nreq++;
            #1;
            done = !stall_mem;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            if (done) break;
            cyc++;
            if (cyc > 100) begin
                checks++; errors++;
                $display("FAIL op_timeout: stall_mem still 1 after %0d cycles, want release", cyc);
                break;
            end
        end
        vld = 1'b0;
        clear_inputs();
    endtask

    initial begin : driver
        req_t nr;
        int   n;
        nr = mkr(1'b0, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        clear_inputs();
        RegWrite_mem = 1'b1; ALUResult_mem = 32'hFFFF; rdAddr_mem = 5'd31;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        checks++;
        if (RegWrite_wb !== 1'b0 || MemtoReg_wb !== 1'b0 || rdAddr_wb !== 5'd0 ||
            ALUResult_wb !== 32'h0 || MemReadData_wb !== 32'h0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rw=%b mtr=%b rd=%0d alu=%h mrd=%h req=%b, want all 0",
                     RegWrite_wb, MemtoReg_wb, rdAddr_wb, ALUResult_wb, MemReadData_wb, dmem_req);
        end
        rst_n = 1'b1; clear_inputs();
        mon_en = 1'b1;
        @(posedge clk); #1;

        // non-mem op, 1-cycle pass-through
        run_op(0,1,0, 3'b000, 32'h1234, 32'h0, 5'd5, -1, 32'h0,
               mk(0,1,0,5'd5,32'h1234,0,32'h0, 0,0,0,0), 0, nr);
        // byte loads: lane 3 of 0x80FF0000 is 0x80
        run_op(1,1,0, F3_LB,  32'h103, 32'h0, 5'd7, 0, 32'h80FF_0000,
               mk(0,1,1,5'd7,32'h103,1,32'hFFFF_FF80, 1,1,0,0), 1, mkr(0,32'h100,4'b0000,32'h0));
        run_op(1,1,0, F3_LBU, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_0000,
               mk(0,1,1,5'd7,32'h103,1,32'h0000_0080, 1,1,0,0), 1, mkr(0,32'h100,4'b0000,32'h0));
        // half loads from the upper half
        run_op(1,1,0, F3_LH,  32'h102, 32'h0, 5'd8, 0, 32'h8001_1234,
               mk(0,1,1,5'd8,32'h102,1,32'hFFFF_8001, 1,1,0,0), 1, mkr(0,32'h100,4'b0000,32'h0));
        run_op(1,1,0, F3_LHU, 32'h102, 32'h0, 5'd8, 0, 32'h8001_1234,
               mk(0,1,1,5'd8,32'h102,1,32'h0000_8001, 1,1,0,0), 1, mkr(0,32'h100,4'b0000,32'h0));
        // word load with 3 wait cycles
        run_op(1,1,0, F3_LW,  32'h10C, 32'h0, 5'd9, 3, 32'hCAFE_F00D,
               mk(0,1,1,5'd9,32'h10C,1,32'hCAFE_F00D, 4,4,0,0), 1, mkr(0,32'h10C,4'b0000,32'h0));
        // stores retire without register write
        run_op(0,1,1, F3_LH,  32'h202, 32'h0000_ABCD, 5'd3, 0, 32'h0,
               mk(0,0,0,5'd3,32'h202,0,32'h0, 1,1,0,0), 1, mkr(1,32'h200,4'b1100,32'hABCD_ABCD));
        run_op(0,0,1, F3_LB,  32'h101, 32'h1234_5678, 5'd0, 1, 32'h0,
               mk(0,0,0,5'd0,32'h101,0,32'h0, 2,2,0,0), 1, mkr(1,32'h100,4'b0010,32'h7878_7878));
        run_op(0,0,1, F3_LW,  32'h400, 32'hDEAD_BEEF, 5'd0, 0, 32'h0,
               mk(0,0,0,5'd0,32'h400,0,32'h0, 1,1,0,0), 1, mkr(1,32'h400,4'b1111,32'hDEAD_BEEF));
        // misaligned: pulse, no request, no stall
        run_op(1,1,0, F3_LW,  32'h301, 32'h0, 5'd4, 0, 32'h0,
               mk(1,0,0,5'd0,32'h0,0,32'h0, 0,0,1,0), 0, nr);
        run_op(1,1,0, F3_LH,  32'h103, 32'h0, 5'd4, 0, 32'h0,
               mk(1,0,0,5'd0,32'h0,0,32'h0, 0,0,1,0), 0, nr);
        run_op(0,0,1, 3'b011, 32'h102, 32'h0, 5'd0, 0, 32'h0,
               mk(1,0,0,5'd0,32'h0,0,32'h0, 0,0,1,0), 0, nr);
        // unused code on an aligned address acts as a word load
        run_op(1,1,0, 3'b111, 32'h108, 32'h0, 5'd10, 0, 32'h1357_9BDF,
               mk(0,1,1,5'd10,32'h108,1,32'h1357_9BDF, 1,1,0,0), 1, mkr(0,32'h108,4'b0000,32'h0));
        // never ready: 16 request cycles, bus error, bubble
        run_op(1,1,0, F3_LW,  32'h600, 32'h0, 5'd11, -1, 32'h0,
               mk(1,0,0,5'd0,32'h0,0,32'h0, 16,16,0,1), 1, mkr(0,32'h600,4'b0000,32'h0));
        run_op(0,1,0, 3'b000, 32'hA5A5, 32'h0, 5'd12, -1, 32'h0,
               mk(0,1,0,5'd12,32'hA5A5,0,32'h0, 0,0,0,0), 0, nr);

        // reset in the third access cycle
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        MemtoReg_mem = 1'b1; RegWrite_mem = 1'b1; funct3_mem = F3_LW;
        ALUResult_mem = 32'h500; rdAddr_mem = 5'd13;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk); #1;
            if (dmem_req) n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL reset_setup: saw %0d access cycles, want 3", n);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; clear_inputs();
        @(negedge clk); #2;
        checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || RegWrite_wb !== 1'b0 ||
            MemtoReg_wb !== 1'b0 || rdAddr_wb !== 5'd0 || ALUResult_wb !== 32'h0 ||
            MemReadData_wb !== 32'h0) begin
            errors++;
            $display("FAIL mid_access_reset: req=%b stall=%b rw=%b mtr=%b rd=%0d alu=%h mrd=%h, want all 0",
                     dmem_req, stall_mem, RegWrite_wb, MemtoReg_wb, rdAddr_wb, ALUResult_wb, MemReadData_wb);
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
        run_op(0,0,0, 3'b000, 32'h42, 32'h0, 5'd1, -1, 32'h0,
               mk(0,0,0,5'd1,32'h42,0,32'h0, 0,0,0,0), 0, nr);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results and %0d requests left, want 0 and 0",
                     exp_q.size(), req_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
